// File: rtl/bcd_pkg.sv
// Shared constants for the binary-to-BCD converter: FSM encoding and digit constants.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package bcd_pkg;

  // Width of one BCD digit and the digit used when the result saturates.
  localparam int         DIGIT_W  = 4;
  localparam logic [3:0] BCD_NINE = 4'h9;

  // Converter FSM encoding.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

endpackage

// File: rtl/bcd_add3.sv
// Single BCD digit adjust for double dabble: adds 3 when the digit is 5 or more.
// Latency: combinational.
// Backpressure: none.
// Ports:
//   dig_i  4-bit BCD digit before adjustment (0..9 in normal operation)
//   dig_o  adjusted digit, ready to be shifted left by one
module bcd_add3
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] dig_i,
  output logic [DIGIT_W-1:0] dig_o
);

  // Inputs never exceed 9, so the sum stays within 4 bits and needs no carry.
  assign dig_o = (dig_i >= 4'd5) ? (dig_i + 4'd3) : dig_i;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential shift-and-add-3 binary to packed BCD converter, one input bit per clock.
// Latency: valid pulses BIN_W+1 edges after the accepting edge (BIN_W+2 cycle start-to-start).
// Backpressure: none; start is only honoured while idle, requests during busy are dropped.
// Ports:
//   clk_i    rising-edge clock
//   rst_ni   asynchronous active-low reset
//   start_i  conversion request, sampled only in IDLE
//   bin_i    unsigned binary operand, captured on the accepting edge
//   busy_o   high while a conversion is running
//   valid_o  one-cycle pulse when bcd_o/ovf_o have been updated
//   bcd_o    packed BCD result, units in [3:0]; held between conversions
//   ovf_o    result did not fit in OUT_DIGITS digits (bcd_o saturated to nines)
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int BIN_W      = 8,
  parameter int OUT_DIGITS = 2,
  parameter int INT_DIGITS = 3
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          start_i,
  input  logic [BIN_W-1:0]              bin_i,
  output logic                          busy_o,
  output logic                          valid_o,
  output logic [OUT_DIGITS*DIGIT_W-1:0] bcd_o,
  output logic                          ovf_o
);

  localparam int SR_W  = INT_DIGITS * DIGIT_W + BIN_W;
  localparam int OUT_W = OUT_DIGITS * DIGIT_W;
  localparam int CNT_W = $clog2(BIN_W);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

  logic [1:0]       state_q, state_d;
  logic [SR_W-1:0]  sr_q, sr_d;
  logic [SR_W-1:0]  sr_adj;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             valid_q, valid_d;
  logic [OUT_W-1:0] bcd_q, bcd_d;
  logic             ovf_q, ovf_d;
  logic             hi_nz;

  // Shift register layout: BCD digits above, binary operand in the low BIN_W bits.
  // Only the BCD digits are adjusted before each shift; the binary part passes through.
  assign sr_adj[BIN_W-1:0] = sr_q[BIN_W-1:0];

  for (genvar g = 0; g < INT_DIGITS; g++) begin : g_digit
    bcd_add3 u_add3 (
      .dig_i (sr_q  [BIN_W + g*DIGIT_W +: DIGIT_W]),
      .dig_o (sr_adj[BIN_W + g*DIGIT_W +: DIGIT_W])
    );
  end

  // Any internal digit above the displayed ones forces saturation.
  if (INT_DIGITS > OUT_DIGITS) begin : g_hi
    assign hi_nz = |sr_q[SR_W-1:BIN_W+OUT_W];
  end else begin : g_no_hi
    assign hi_nz = 1'b0;
  end

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    valid_d = 1'b0;
    bcd_d   = bcd_q;
    ovf_d   = ovf_q;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          sr_d    = {{(INT_DIGITS*DIGIT_W){1'b0}}, bin_i};
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        sr_d  = sr_adj << 1;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        if (hi_nz) begin
          bcd_d = {OUT_DIGITS{BCD_NINE}};
          ovf_d = 1'b1;
        end else begin
          bcd_d = sr_q[BIN_W +: OUT_W];
          ovf_d = 1'b0;
        end
        valid_d = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      bcd_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      bcd_q   <= bcd_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy_o  = busy_q;
  assign valid_o = valid_q;
  assign bcd_o   = bcd_q;
  assign ovf_o   = ovf_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq with a scoreboard of expected {bcd, ovf}.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_bin_to_bcd_seq;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] bin;
  logic       busy;
  logic       valid;
  logic [7:0] bcd;
  logic       ovf;

  int n_vec = 0;
  int n_err = 0;
  int valid_cnt = 0;

  logic [8:0] sb[$];
  logic [8:0] prev_out = '0;
  logic [8:0] exp_v;

  bin_to_bcd_seq #(
    .BIN_W      (8),
    .OUT_DIGITS (2),
    .INT_DIGITS (3)
  ) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .start_i (start),
    .bin_i   (bin),
    .busy_o  (busy),
    .valid_o (valid),
    .bcd_o   (bcd),
    .ovf_o   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: saturate at 99, pack tens/units, ovf flag in bit 0.
  function automatic logic [8:0] exp_of(input int b);
    int v;
    v = (b > 99) ? 99 : b;
    return {4'(v / 10), 4'(v % 10), (b > 99) ? 1'b1 : 1'b0};
  endfunction

  // Scoreboard on valid, and hold check on bcd/ovf in every other cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_out = '0;
    end else if (valid) begin
      valid_cnt++;
      n_vec++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_valid: got bcd=%h ovf=%b, required no valid pulse", bcd, ovf);
      end else begin
        exp_v = sb.pop_front();
        if ({bcd, ovf} !== exp_v) begin
          n_err++;
          $display("FAIL scoreboard: got bcd=%h ovf=%b, required bcd=%h ovf=%b",
                   bcd, ovf, exp_v[8:1], exp_v[0]);
        end
      end
      prev_out = {bcd, ovf};
    end else begin
      n_vec++;
      if ({bcd, ovf} !== prev_out) begin
        n_err++;
        $display("FAIL output_hold: got bcd=%h ovf=%b, required bcd=%h ovf=%b",
                 bcd, ovf, prev_out[8:1], prev_out[0]);
      end
    end
  end

  task automatic test_reset();
    rst_n = 1'b1;
    start = 1'b0;
    bin   = '0;
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({busy, valid, bcd, ovf} !== 11'h000) begin
      n_err++;
      $display("FAIL reset_async: got busy=%b valid=%b bcd=%h ovf=%b, required all zero",
               busy, valid, bcd, ovf);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_vec++;
      if ({busy, valid, bcd, ovf} !== 11'h000) begin
        n_err++;
        $display("FAIL reset_idle: cycle %0d got busy=%b valid=%b bcd=%h ovf=%b, required all zero",
                 i, busy, valid, bcd, ovf);
      end
    end
  endtask

  task automatic test_latency();
    start = 1'b1;
    bin   = 8'd42;
    sb.push_back(exp_of(42));
    @(posedge clk);
    for (int k = 0; k <= 10; k++) begin
      @(negedge clk);
      if (k == 0) start = 1'b0;
      n_vec++;
      if (k < 9 && {busy, valid} !== 2'b10) begin
        n_err++;
        $display("FAIL latency_busy: k=%0d got busy=%b valid=%b, required busy=1 valid=0", k, busy, valid);
      end
      if (k == 9 && {busy, valid, bcd, ovf} !== {2'b01, 8'h42, 1'b0}) begin
        n_err++;
        $display("FAIL latency_done: got busy=%b valid=%b bcd=%h ovf=%b, required busy=0 valid=1 bcd=42 ovf=0",
                 busy, valid, bcd, ovf);
      end
      if (k == 10 && {busy, valid} !== 2'b00) begin
        n_err++;
        $display("FAIL latency_after: got busy=%b valid=%b, required both 0", busy, valid);
      end
    end
  endtask

  // Start is held high in each valid cycle so conversions run with no bubble.
  task automatic test_back_to_back();
    int vals[3] = '{99, 100, 255};
    int k;
    @(negedge clk);
    start = 1'b1;
    bin   = vals[0][7:0];
    sb.push_back(exp_of(vals[0]));
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      n_vec++;
      if (busy !== 1'b1) begin
        n_err++;
        $display("FAIL b2b_accept: item %0d got busy=%b, required 1", i, busy);
      end
      k = 0;
      while (!valid && k < 30) begin
        @(negedge clk);
        k++;
      end
      n_vec++;
      if (k !== 9) begin
        n_err++;
        $display("FAIL b2b_latency: item %0d got %0d, required 9", i, k);
      end
      if (i < 2) begin
        start = 1'b1;
        bin   = vals[i+1][7:0];
        sb.push_back(exp_of(vals[i+1]));
      end
    end
  endtask

  task automatic test_ignore_busy();
    int v0;
    @(negedge clk);
    v0    = valid_cnt;
    start = 1'b1;
    bin   = 8'd7;
    sb.push_back(exp_of(7));
    @(posedge clk);
    for (int k = 0; k <= 30; k++) begin
      @(negedge clk);
      if (k == 0) start = 1'b0;
      if (k == 4) begin
        start = 1'b1;
        bin   = 8'd63;
      end
      if (k == 5) start = 1'b0;
    end
    n_vec++;
    if (valid_cnt - v0 !== 1 || bcd !== 8'h07 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL ignore_busy: got %0d valids bcd=%h busy=%b, required 1 valid bcd=07 busy=0",
               valid_cnt - v0, bcd, busy);
    end
  endtask

  task automatic test_reset_abort();
    int v0;
    int k;
    @(negedge clk);
    v0    = valid_cnt;
    start = 1'b1;
    bin   = 8'd88;
    @(posedge clk);
    for (int j = 0; j <= 5; j++) begin
      @(negedge clk);
      if (j == 0) start = 1'b0;
    end
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({busy, valid, bcd, ovf} !== 11'h000) begin
      n_err++;
      $display("FAIL abort_async: got busy=%b valid=%b bcd=%h ovf=%b, required all zero",
               busy, valid, bcd, ovf);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    n_vec++;
    if (valid_cnt !== v0 || busy !== 1'b0 || bcd !== 8'h00) begin
      n_err++;
      $display("FAIL abort_no_valid: got %0d valids busy=%b bcd=%h, required 0 valids busy=0 bcd=00",
               valid_cnt - v0, busy, bcd);
    end
    start = 1'b1;
    bin   = 8'd13;
    sb.push_back(exp_of(13));
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (!valid && k < 30) begin
      @(negedge clk);
      k++;
    end
    n_vec++;
    if (k !== 9 || bcd !== 8'h13 || ovf !== 1'b0) begin
      n_err++;
      $display("FAIL abort_restart: got latency %0d bcd=%h ovf=%b, required 9 bcd=13 ovf=0", k, bcd, ovf);
    end
  endtask

  task automatic test_sweep();
    int k;
    @(negedge clk);
    start = 1'b1;
    bin   = 8'd0;
    sb.push_back(exp_of(0));
    for (int b = 0; b < 256; b++) begin
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      k = 0;
      while (!valid && k < 30) begin
        @(negedge clk);
        k++;
      end
      n_vec++;
      if (k !== 9) begin
        n_err++;
        $display("FAIL sweep_latency: bin=%0d got %0d, required 9", b, k);
      end
      if (b < 255) begin
        start = 1'b1;
        bin   = 8'(b + 1);
        sb.push_back(exp_of(b + 1));
      end
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_latency();
    test_back_to_back();
    test_ignore_busy();
    test_reset_abort();
    test_sweep();
    n_vec++;
    if (sb.size() !== 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d pending, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/bin_to_bcd_seq.md
Name: bin_to_bcd_seq

Overview:
- Sequential binary-to-BCD converter using shift-and-add-3 (double dabble), one bit per clock.
- Sits directly upstream of the two-digit seven-segment display driver. Its packed 2-digit BCD output feeds that driver's 8-bit BCD input: units in [3:0], tens in [7:4].
- Start/valid handshake lets any binary producer (counter, switch input) request a conversion.
- Values that do not fit in the display digits saturate to all-nines and raise an overflow flag.

Parameters:
- BIN_W, 8, width of binary input; legal range 4..16.
- OUT_DIGITS, 2, number of BCD digits presented on bcd.
- INT_DIGITS, 3, internal BCD digits. Must satisfy 10^INT_DIGITS > 2^BIN_W - 1 and INT_DIGITS >= OUT_DIGITS.

Ports:
- clk  in  1  system clock, rising-edge active.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  conversion request; sampled only in IDLE.
- bin  in  BIN_W  unsigned binary value; captured on the accepting edge, ignored otherwise.
- busy  out  1  high while a conversion is in progress.
- valid  out  1  one-cycle pulse: bcd/ovf updated.
- bcd  out  4*OUT_DIGITS  packed BCD result, least significant digit in [3:0]; held between conversions.
- ovf  out  1  result exceeded 10^OUT_DIGITS - 1; held with bcd.

Behaviour:
- Reset (rst_n low, asynchronous assert; release is seen at the next rising edge):
  - state=IDLE, busy=0, valid=0, bcd=0, ovf=0, shift register=0, bit counter=0.
- State machine, three states:
  - IDLE: when start=1, load shift register {INT_DIGITS*4 zeros, bin}, counter=0, busy<=1, go to SHIFT. When start=0, stay.
  - SHIFT: each cycle, for every internal BCD digit >= 5 add 3 (combinational), then shift the whole register left by 1, counter++. When counter == BIN_W-1 on this edge (the BIN_W-th shift), go to DONE.
  - DONE: register result. If any internal digit at index >= OUT_DIGITS is nonzero, bcd<=all 4'h9 and ovf<=1; else bcd<=low OUT_DIGITS digits and ovf<=0. Then valid<=1, busy<=0, go to IDLE.
- valid is 0 in every cycle except the one following the DONE edge.
- Latency: the start-accept edge is edge 0. SHIFT occupies edges 1..BIN_W; DONE is edge BIN_W+1. valid is high in the cycle after edge BIN_W+1 (cycle 10 for BIN_W=8).
- busy timing: rises in the cycle after the accept edge, falls in the same cycle valid rises. Minimum start-to-start spacing is BIN_W+2 cycles.
- start while busy=1 is ignored; it is not queued and bin is not captured.
- start high in the valid cycle (FSM already IDLE) is accepted. Back-to-back conversions with no bubble are required.
- bcd/ovf change only at the DONE edge or on reset; never glitch mid-conversion.
- Reset mid-conversion aborts immediately to the reset values; no valid pulse is produced.
- bin=0 yields bcd=0, ovf=0. Maximum bin (2^BIN_W-1) must convert exactly internally before saturation.
- Widths:
  - Counter is ceil(log2(BIN_W)) bits.
  - Shift register is INT_DIGITS*4+BIN_W bits.
  - Add-3 is a 4-bit add with no carry out (input <= 9 guarantees no overflow).

Decomposition:
- Shared package bcd_pkg:
  - FSM state encoding constants (IDLE, SHIFT, DONE).
  - Digit width constant (4) and the BCD saturation digit 4'h9.
- One sub-module is natural: bcd_add3, a combinational 4-bit digit adjust (out = in>=5 ? in+3 : in). Instantiate it INT_DIGITS times in a generate loop.

Test Plan:
- Reset then idle 20 cycles -> busy=0, valid=0, bcd=8'h00, ovf=0 throughout.
- start with bin=42 -> valid exactly 10 cycles after the accept edge, bcd=8'h42, ovf=0, busy high for cycles 1..9.
- bin=99, then bin=100, then bin=255, each back-to-back with start high in the valid cycle -> bcd=8'h99/ovf=0, then 8'h99/ovf=1, then 8'h99/ovf=1. No idle cycles between conversions.
- bin=7 accepted; start pulsed with bin=63 at cycle 4 -> only one valid, bcd=8'h07; second request ignored.
- bin=88 accepted; rst_n low at cycle 5 for 2 cycles -> outputs reset immediately, no valid pulse; a new start with bin=13 then yields bcd=8'h13.
- Exhaustive sweep bin=0..255 -> each result equals min(bin,99) in BCD, with ovf=(bin>99).
